// File: rtl/condicionador_botoes.sv
// condicionador_botoes: conditions the three raw stopwatch buttons
// (count, pause, stop) into debounced levels and one-cycle press pulses.
// Each channel: two-flop synchronizer, stability counter, press-edge pulse.
// Optional build macro CONDICIONADOR_EXCLUSIVO_EN: at most one pulse per
// cycle, priority para > pausa > conta; lower-priority pulses are dropped.
// Channel index: [0] = conta, [1] = pausa, [2] = para.
module condicionador_botoes #(
  parameter int unsigned estavel = 1000000,
  parameter int unsigned largura = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_conta,
  input  logic       key_pausa,
  input  logic       key_para,
  output logic       conta,
  output logic       pausa,
  output logic       para,
  output logic [2:0] pressionado
);

  localparam int unsigned        LIMITE_INT = estavel - 1;
  localparam logic [largura-1:0] LIMITE     = LIMITE_INT[largura-1:0];
  localparam logic [largura-1:0] UM         = {{(largura-1){1'b0}}, 1'b1};

  logic [2:0]              key_raw;
  logic [2:0]              s1_q, s1_d;
  logic [2:0]              s2_q, s2_d;
  logic [2:0]              est_q, est_d;
  logic [2:0]              pulso_q, pulso_d;
  logic [2:0][largura-1:0] cnt_q, cnt_d;
  logic [2:0]              flip_press;

  assign key_raw = {key_para, key_pausa, key_conta};

  // Synchronizer shift and per-channel stability counter / level update.
  always_comb begin
    s1_d       = key_raw;
    s2_d       = s1_q;
    est_d      = est_q;
    cnt_d      = cnt_q;
    flip_press = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (s2_q[i] == est_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LIMITE) begin
        est_d[i]      = s2_q[i];
        cnt_d[i]      = '0;
        // only a released->pressed flip (est 1 -> 0) is a press
        flip_press[i] = est_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + UM;
      end
    end
  end

  // Press pulses, optionally arbitrated down to a single command.
  always_comb begin
    pulso_d = flip_press;
`ifdef CONDICIONADOR_EXCLUSIVO_EN
    if (flip_press[2]) begin
      pulso_d = 3'b100;
    end else if (flip_press[1]) begin
      pulso_d = 3'b010;
    end
`endif
  end

  // State registers; everything returns to the released state on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '1;
      s2_q    <= '1;
      est_q   <= '1;
      cnt_q   <= '0;
      pulso_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  assign conta       = pulso_q[0];
  assign pausa       = pulso_q[1];
  assign para        = pulso_q[2];
  assign pressionado = ~est_q;

endmodule
